// File: rtl/bus_fabric.sv
// bus_fabric: registered address-decoding interconnect with error and timeout completion
module bus_fabric #(
  parameter int N_SLAVES = 4,
  parameter int SEL_LSB  = 28,
  parameter int TIMEOUT  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     proc_rd_en_i,
  input  logic                     proc_wr_en_i,
  input  logic [31:0]              proc_addr_i,
  input  logic [31:0]              proc_data_i,
  output logic [31:0]              proc_data_o,
  output logic                     proc_ack_o,
  output logic                     proc_err_o,
  output logic [N_SLAVES-1:0]      slv_rd_en_o,
  output logic [N_SLAVES-1:0]      slv_wr_en_o,
  output logic [31:0]              slv_addr_o,
  output logic [31:0]              slv_data_o,
  input  logic [32*N_SLAVES-1:0]   slv_data_i,
  input  logic [N_SLAVES-1:0]      slv_ack_i,
  output logic [7:0]               err_count_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam int TW = $clog2(TIMEOUT);
  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, sel_data;
  logic              wr_q, wr_d, err_q, err_d, sel_ack;
  logic [3:0]        idx_q, idx_d, idx_new;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [N_SLAVES-1:0] onehot;
  logic              bad_req;
  assign idx_new = proc_addr_i[SEL_LSB+3:SEL_LSB];
  assign bad_req = (proc_rd_en_i & proc_wr_en_i) | ({28'd0, idx_new} >= 32'(N_SLAVES));
  // select the addressed slave's ack and read data from the latched index
  always_comb begin
    onehot   = '0;
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int k = 0; k < N_SLAVES; k++)
      if (idx_q == 4'(k)) begin
        onehot[k] = 1'b1;
        sel_ack   = slv_ack_i[k];
        sel_data  = slv_data_i[32*k +: 32];
      end
  end
  // next-state and datapath updates for the IDLE/ACCESS/RESP transaction flow
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (proc_rd_en_i | proc_wr_en_i) begin
        addr_d  = proc_addr_i;
        wdata_d = proc_data_i;
        wr_d    = proc_wr_en_i;
        idx_d   = idx_new;
        timer_d = '0;
        err_d   = bad_req;
        state_d = bad_req ? RESP : ACCESS;
        data_d  = bad_req ? 32'd0 : data_q;
      end
      ACCESS: if (sel_ack) begin
        state_d = RESP;
        err_d   = 1'b0;
        data_d  = wr_q ? 32'd0 : sel_data;
      end else if (timer_q == TW'(TIMEOUT-1)) begin
        state_d = RESP;
        err_d   = 1'b1;
        data_d  = 32'd0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = (err_q && cnt_q != 8'd255) ? cnt_q + 8'd1 : cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously so strobes drop at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  assign slv_rd_en_o = (state_q == ACCESS && !wr_q) ? onehot : '0;
  assign slv_wr_en_o = (state_q == ACCESS &&  wr_q) ? onehot : '0;
  assign slv_addr_o  = addr_q;
  assign slv_data_o  = wdata_q;
  assign proc_data_o = data_q;
  assign proc_ack_o  = state_q == RESP;
  assign proc_err_o  = state_q == RESP && err_q;
  assign err_count_o = cnt_q;
endmodule
